// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous-read memory port between the core (A) and the debug/loader port (B).
module mem_port_arbiter #(
    parameter int WORD_SIZE  = 20,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WAIT   = 3,
    parameter int BURST_MAX  = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  a_req,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [WORD_SIZE-1:0]  a_wdata,
    input  logic                  a_write,
    output logic                  a_grant,
    output logic                  core_stall,
    output logic                  a_rvalid,
    input  logic                  b_req,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [WORD_SIZE-1:0]  b_wdata,
    input  logic                  b_write,
    input  logic                  b_lock,
    output logic                  b_grant,
    output logic                  b_rvalid,
    input  logic                  halt_req,
    output logic                  halt_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    output logic                  mem_write,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);
    typedef enum logic [1:0] {RUN, BURST, HALT} state_t;
    localparam logic [3:0] WMAX = 4'(MAX_WAIT);
    localparam logic [7:0] BMAX = 8'(BURST_MAX);
    state_t     state, state_nx;
    logic [3:0] wait_cnt, wait_nx;
    logic [7:0] burst_cnt, burst_nx;
    always_comb begin
        a_grant  = 1'b0;
        b_grant  = 1'b0;
        state_nx = state;
        wait_nx  = wait_cnt;
        burst_nx = burst_cnt;
        case (state)
            RUN: begin
                b_grant = b_req && (!a_req || wait_cnt == WMAX);
                a_grant = a_req && !b_grant;
                wait_nx = (b_grant || !b_req) ? 4'd0 : (a_req && wait_cnt != WMAX) ? wait_cnt + 4'd1 : wait_cnt;
                if (b_grant && b_lock && BURST_MAX > 1) begin
                    state_nx = BURST;
                    burst_nx = 8'd1;
                end else if (halt_req) begin
                    state_nx = HALT;
                end
            end
            BURST: begin
                b_grant  = b_req;
                burst_nx = burst_cnt + {7'd0, b_grant};
                if (!b_req || !b_lock || burst_nx == BMAX) begin
                    state_nx = halt_req ? HALT : RUN;
                    burst_nx = 8'd0;
                    wait_nx  = 4'd0;
                end
            end
            HALT: begin
                b_grant  = b_req;
                state_nx = halt_req ? HALT : RUN;
            end
            default: state_nx = RUN;
        endcase
        // reset overrides everything so no access leaks out while reset_n is low
        if (!reset_n) begin
            a_grant = 1'b0;
            b_grant = 1'b0;
        end
    end
    assign core_stall = !reset_n || state == HALT || (a_req && !a_grant);
    assign mem_addr   = b_grant ? b_addr : a_addr;
    assign mem_wdata  = b_grant ? b_wdata : a_wdata;
    assign mem_write  = (a_grant && a_write) || (b_grant && b_write);
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= RUN;
            wait_cnt  <= 4'd0;
            burst_cnt <= 8'd0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            halt_ack  <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            burst_cnt <= burst_nx;
            a_rvalid  <= a_grant;
            b_rvalid  <= b_grant;
            halt_ack  <= state_nx == HALT;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors with hand-computed expectations, checked through a scoreboard queue.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        a_req = 1'b0, a_write = 1'b0, b_req = 1'b0, b_write = 1'b0, b_lock = 1'b0, halt_req = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0, mem_addr;
    logic [19:0] a_wdata = '0, b_wdata = '0, mem_wdata, mem_rdata;
    logic        a_grant, core_stall, a_rvalid, b_grant, b_rvalid, halt_ack, mem_write;
    logic [19:0] mem [0:65535];
    typedef struct {
        logic [7:0]  e;
        logic [15:0] addr;
        logic [19:0] wd;
        logic [19:0] rd;
        string       nm;
    } exp_t;
    exp_t q[$];
    exp_t x;
    int checks = 0;
    int errors = 0;
    mem_port_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_write(a_write),
        .a_grant(a_grant), .core_stall(core_stall), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_write(b_write), .b_lock(b_lock),
        .b_grant(b_grant), .b_rvalid(b_rvalid), .halt_req(halt_req), .halt_ack(halt_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );
    always #5 clk = ~clk;
    // memory model with one-cycle read latency
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end
    // in bits: reset_n a_req a_write b_req b_write b_lock halt_req
    // e bits:  a_grant b_grant core_stall mem_write a_rvalid b_rvalid halt_ack check_rdata
    task automatic cyc(input logic [6:0] in, input logic [15:0] aa, input logic [15:0] ba,
                       input logic [19:0] wd, input logic [7:0] e, input logic [15:0] ea,
                       input logic [19:0] erd, input string nm);
        exp_t t;
        @(negedge clk);
        {reset_n, a_req, a_write, b_req, b_write, b_lock, halt_req} = in;
        a_addr  = aa;
        b_addr  = ba;
        b_wdata = wd;
        a_wdata = ~wd;
        t.e = e; t.addr = ea; t.wd = e[6] ? wd : ~wd; t.rd = erd; t.nm = nm;
        q.push_back(t);
    endtask
    always @(negedge clk) begin
        #2;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if ({a_grant, b_grant, core_stall, mem_write, a_rvalid, b_rvalid, halt_ack} !== x.e[7:1]) begin
                errors++;
                $display("FAIL %s flags got %b want %b", x.nm,
                         {a_grant, b_grant, core_stall, mem_write, a_rvalid, b_rvalid, halt_ack}, x.e[7:1]);
            end
            checks++;
            if (mem_addr !== x.addr) begin
                errors++;
                $display("FAIL %s mem_addr got %h want %h", x.nm, mem_addr, x.addr);
            end
            if (x.e[4]) begin
                checks++;
                if (mem_wdata !== x.wd) begin
                    errors++;
                    $display("FAIL %s mem_wdata got %h want %h", x.nm, mem_wdata, x.wd);
                end
            end
            if (x.e[0]) begin
                checks++;
                if (mem_rdata !== x.rd) begin
                    errors++;
                    $display("FAIL %s mem_rdata got %h want %h", x.nm, mem_rdata, x.rd);
                end
            end
        end
    end
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        cyc(7'b0111100, 16'h0010, 16'h0700, 20'h0, 8'b00100000, 16'h0010, 20'h0, "reset0");
        cyc(7'b0111100, 16'h0010, 16'h0700, 20'h0, 8'b00100000, 16'h0010, 20'h0, "reset1");
        for (int i = 0; i < 4; i++)
            cyc(7'b1100000, 16'(16'h0010 + i), 16'h0, 20'h0, i == 0 ? 8'b10000000 : 8'b10001000,
                16'(16'h0010 + i), 20'h0, "core_only");
        cyc(7'b1001100, 16'h0013, 16'h0100, 20'h12345, 8'b01011000, 16'h0100, 20'h0, "idle_wr");
        cyc(7'b1001000, 16'h0013, 16'h0100, 20'h0, 8'b01000100, 16'h0100, 20'h0, "b_rd");
        cyc(7'b1000000, 16'h0013, 16'h0100, 20'h0, 8'b00000101, 16'h0013, 20'h12345, "b_rdata");
        for (int j = 0; j < 8; j++)
            cyc(7'b1101000, 16'h0020, 16'h0200, 20'h0,
                (j % 4 == 3) ? 8'b01101000 : (j == 0) ? 8'b10000000 : (j == 4) ? 8'b10000100 : 8'b10001000,
                (j % 4 == 3) ? 16'h0200 : 16'h0020, 20'h0, "steal");
        cyc(7'b1000000, 16'h0020, 16'h0200, 20'h0, 8'b00000100, 16'h0020, 20'h0, "idle1");
        for (int j = 0; j < 15; j++)
            cyc(j < 14 ? 7'b1101110 : 7'b1101000, 16'h0030, 16'h0300, 20'h0ABCD,
                j == 0 ? 8'b10000000 : j < 3 ? 8'b10001000 : j == 3 ? 8'b01111000 :
                j < 11 ? 8'b01110100 : j == 11 ? 8'b10000100 : j < 14 ? 8'b10001000 : 8'b01101000,
                ((j >= 3 && j <= 10) || j == 14) ? 16'h0300 : 16'h0030, 20'h0, "burst_cap");
        cyc(7'b1000000, 16'h0030, 16'h0300, 20'h0, 8'b00000100, 16'h0030, 20'h0, "idle2");
        cyc(7'b1100001, 16'h0040, 16'h0500, 20'h0, 8'b10000000, 16'h0040, 20'h0, "halt_req");
        for (int i = 0; i < 16; i++)
            cyc(7'b1101101, 16'h0040, 16'(16'h0500 + i), 20'(20'hA0000 + i),
                i == 0 ? 8'b01111010 : 8'b01110110, 16'(16'h0500 + i), 20'h0, "halt_wr");
        cyc(7'b1101011, 16'h0040, 16'h0505, 20'h0, 8'b01100110, 16'h0505, 20'h0, "halt_rd");
        cyc(7'b1100000, 16'h0040, 16'h0505, 20'h0, 8'b00100111, 16'h0040, 20'hA0005, "halt_drop");
        cyc(7'b1100000, 16'h0040, 16'h0505, 20'h0, 8'b10000000, 16'h0040, 20'h0, "resume");
        cyc(7'b1001110, 16'h0040, 16'h0600, 20'h55555, 8'b01011000, 16'h0600, 20'h0, "rburst1");
        for (int i = 0; i < 4; i++)
            cyc(7'b1001110, 16'h0040, 16'h0600, 20'h55555, 8'b01010100, 16'h0600, 20'h0, "rburst");
        cyc(7'b0001110, 16'h0040, 16'h0600, 20'h55555, 8'b00100100, 16'h0040, 20'h0, "mid_reset");
        cyc(7'b1101110, 16'h0040, 16'h0600, 20'h55555, 8'b10000000, 16'h0040, 20'h0, "post_reset");
        cyc(7'b1000000, 16'h0040, 16'h0600, 20'h0, 8'b00001000, 16'h0040, 20'h0, "idle3");
        cyc(7'b1001001, 16'h0040, 16'h0700, 20'h0, 8'b01000000, 16'h0700, 20'h0, "b_halt_same");
        cyc(7'b1000000, 16'h0040, 16'h0700, 20'h0, 8'b00100110, 16'h0040, 20'h0, "halt_after_b");
        cyc(7'b1000000, 16'h0040, 16'h0700, 20'h0, 8'b00000000, 16'h0040, 20'h0, "back_run");
        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single synchronous-read memory port, including the hardware-register window, between two requesters:
  - Requester A: the lisp core; it gains a stall input.
  - Requester B: the debug/loader port.
- Core has default priority. A wait counter guarantees B forward progress.
- B can lock the port for bursts, or halt the core for exclusive access (program load, inspection).
- Sits between core/debug logic and the memory; all memory-side signals pass through this block.

Parameters:
- WORD_SIZE, 20, data width of memory words.
- ADDR_WIDTH, 16, width of memory/register address.
- MAX_WAIT, 3, cycles B may wait while A is requesting before it steals one cycle (1..15).
- BURST_MAX, 8, maximum consecutive B grants under b_lock (1..255).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- a_req  in  1  core memory request
- a_addr  in  ADDR_WIDTH  core address
- a_wdata  in  WORD_SIZE  core write data
- a_write  in  1  core write enable
- a_grant  out  1  core access performed this cycle
- core_stall  out  1  core must hold state and repeat its request
- a_rvalid  out  1  mem_rdata belongs to A's previous-cycle grant
- b_req  in  1  debug memory request
- b_addr  in  ADDR_WIDTH  debug address
- b_wdata  in  WORD_SIZE  debug write data
- b_write  in  1  debug write enable
- b_lock  in  1  keep ownership for back-to-back B accesses
- b_grant  out  1  debug access performed this cycle
- b_rvalid  out  1  mem_rdata belongs to B's previous-cycle grant
- halt_req  in  1  debug requests core halt
- halt_ack  out  1  core halted; B has exclusive port
- mem_addr  out  ADDR_WIDTH  to memory/register decode
- mem_wdata  out  WORD_SIZE  to memory
- mem_write  out  1  to memory
- mem_rdata  in  WORD_SIZE  from memory; 1-cycle read latency

Behaviour:
- Grant, stall and mem_* outputs are combinational from state, counters and requests.
- Datapath muxing:
  - mem_addr/mem_wdata are taken from the granted requester; when neither is granted they carry A's values.
  - mem_write = (a_grant & a_write) | (b_grant & b_write). Never asserted without a grant.
- Read data: a_rvalid/b_rvalid are registered copies of a_grant/b_grant. Read data is mem_rdata; no data register.
- Stall: core_stall = (a_req & !a_grant) in RUN/BURST; core_stall = 1 in HALT.
- At most one grant per cycle.
- Reset (reset_n low at clk edge): state=RUN, wait_cnt=0, burst_cnt=0, a_rvalid=b_rvalid=0, halt_ack=0.
  - While reset_n is low, grants and mem_write are forced 0 and core_stall is forced 1.
  - Reset mid-burst or mid-halt returns to RUN with no pending grant.
- State RUN:
  - Grant B if b_req & (!a_req | wait_cnt==MAX_WAIT); else grant A if a_req.
  - wait_cnt: +1 when b_req & a_req & !b_grant, saturating at MAX_WAIT; cleared on b_grant or !b_req.
  - B granted with b_lock=1 and BURST_MAX>1: next state BURST, burst_cnt=1.
  - Else, if halt_req: next state HALT; the current cycle is still arbitrated normally.
- State BURST:
  - b_grant = b_req; A is never granted.
  - Each B grant increments burst_cnt.
  - Exit after the cycle where !b_req, !b_lock, or burst_cnt reaches BURST_MAX on a grant.
  - Exit target: HALT if halt_req, else RUN. burst_cnt and wait_cnt are cleared on exit.
- State HALT:
  - halt_ack=1 (registered; asserts the cycle HALT is entered).
  - b_grant = b_req; b_lock is ignored.
  - On halt_req=0: next state RUN; halt_ack drops the same edge. First A grant is possible in that RUN cycle.
- halt_req and b_req rising in the same RUN cycle: B arbitrated normally that cycle, then HALT.
- Hardware-register addresses are passed through unaltered; register side effects follow the grant.

Test Plan:
- Core only: a_req=1 every cycle, addr 0x0010..0x0013 -> a_grant=1 every cycle, core_stall=0, a_rvalid=1 one cycle later each time.
- Starvation steal, MAX_WAIT=3: a_req and b_req held high -> B waits 3 cycles, b_grant on cycle 4 with core_stall=1, then A resumes; pattern repeats every 4 cycles.
- Idle steal: a_req=0, b_req=1 write 0x12345 to 0x0100 -> b_grant same cycle, mem_write=1, mem_wdata=0x12345; a later B read returns 0x12345 with b_rvalid.
- Burst cap, BURST_MAX=8: b_lock=1 and b_req=1 for 12 cycles, a_req=1 -> exactly 8 consecutive B grants, then A granted, then B wait/steal resumes.
- Halt: halt_req=1 during a_req traffic -> halt_ack next cycle, core_stall=1, a_grant=0 throughout; B writes 16 words. Drop halt_req -> a_grant within 1 cycle, halt_ack=0.
- Reset mid-burst: reset_n=0 at burst_cnt=5 -> next cycle state RUN, all rvalids 0, no grants during reset, mem_write=0.
